// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe
// ---------------------------------------------------------------------------
// Two-stage pipelined SIMD ALU for the FIR vector datapath. Each operation
// works on LANES signed lanes of LANE_W bits. A per-lane accumulator bank
// backs the VMAC / VACCRD tap-summation ops.
//
// Pipeline:
//   stage 1 : registers opcode and operands (s1_*)
//   stage 2 : computes the lane results and registers them with the flags
//             (out_result / out_ovf / out_zero / out_valid)
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_op [2:0]           opcode (VADD, VSUB, VAND, VMUL, VMAC, VROT, VACCRD, VPASS)
//   in_a, in_b            operand vectors, lane i at [i*LANE_W +: LANE_W]
//   out_valid / out_ready output handshake
//   out_result            result vector
//   out_ovf [LANES-1:0]   per-lane signed overflow flag
//   out_zero              high when the whole out_result is zero
//
// Build option:
//   VALU_SAT_EN  defined   -> VADD/VSUB/VMUL/VMAC saturate each lane
//                undefined -> those ops wrap modulo 2^LANE_W
//   out_ovf is identical in both builds.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and a producer holds its data
// stable while valid is high and ready is low.
// ---------------------------------------------------------------------------
module vector_alu_pipe #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [LANES*LANE_W-1:0]   in_a,
  input  logic [LANES*LANE_W-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_result,
  output logic [LANES-1:0]          out_ovf,
  output logic                      out_zero
);

  localparam int VW = LANES * LANE_W;
  // Wide enough to hold acc + full product exactly, with headroom.
  localparam int XW = 2 * LANE_W + 2;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_MAC   = 3'b100;
  localparam logic [2:0] OP_ROT   = 3'b101;
  localparam logic [2:0] OP_ACCRD = 3'b110;
  localparam logic [2:0] OP_PASS  = 3'b111;

  // Lane limits, sign-extended to XW for exact signed comparison.
  localparam logic signed [XW-1:0] LANE_MAX =
    {{(XW-LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
  localparam logic signed [XW-1:0] LANE_MIN =
    {{(XW-LANE_W+1){1'b1}}, {(LANE_W-1){1'b0}}};

  function automatic logic signed [XW-1:0] sext(input logic [LANE_W-1:0] v);
    return {{(XW-LANE_W){v[LANE_W-1]}}, v};
  endfunction

  // -------------------------------------------------------------------------
  // Stage registers and accumulator bank
  // -------------------------------------------------------------------------
  logic              s1_valid;
  logic [2:0]        s1_op;
  logic [VW-1:0]     s1_a;
  logic [VW-1:0]     s1_b;
  logic [LANE_W-1:0] acc [LANES];

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;

  // -------------------------------------------------------------------------
  // Stage-2 datapath (combinational from stage-1 contents)
  // -------------------------------------------------------------------------
  logic [VW-1:0]     res_next;
  logic [LANES-1:0]  ovf_next;
  logic [LANE_W-1:0] acc_next [LANES];
  logic              acc_we;

  logic signed [XW-1:0] ea;
  logic signed [XW-1:0] eb;
  logic signed [XW-1:0] eacc;
  logic signed [XW-1:0] exact;
  logic                 arith;
  logic [LANE_W-1:0]    lane_arith;
  logic [LANE_W-1:0]    lane_res;

  always_comb begin
    res_next   = '0;
    ovf_next   = '0;
    ea         = '0;
    eb         = '0;
    eacc       = '0;
    exact      = '0;
    arith      = 1'b0;
    lane_arith = '0;
    lane_res   = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_next[i] = '0;
    end

    for (int i = 0; i < LANES; i++) begin
      ea    = sext(s1_a[i*LANE_W +: LANE_W]);
      eb    = sext(s1_b[i*LANE_W +: LANE_W]);
      eacc  = sext(acc[i]);
      exact = '0;
      arith = 1'b0;

      // Exact signed result; the full product is formed before any
      // truncation or clamping.
      case (s1_op)
        OP_ADD: begin exact = ea + eb;          arith = 1'b1; end
        OP_SUB: begin exact = ea - eb;          arith = 1'b1; end
        OP_MUL: begin exact = ea * eb;          arith = 1'b1; end
        OP_MAC: begin exact = eacc + (ea * eb); arith = 1'b1; end
        default: begin exact = '0;              arith = 1'b0; end
      endcase

      ovf_next[i] = arith && ((exact > LANE_MAX) || (exact < LANE_MIN));

`ifdef VALU_SAT_EN
      if (ovf_next[i]) begin
        lane_arith = (exact < LANE_MIN) ? LANE_MIN[LANE_W-1:0]
                                        : LANE_MAX[LANE_W-1:0];
      end else begin
        lane_arith = exact[LANE_W-1:0];
      end
`else
      lane_arith = exact[LANE_W-1:0];
`endif

      case (s1_op)
        OP_AND:   lane_res = s1_a[i*LANE_W +: LANE_W] & s1_b[i*LANE_W +: LANE_W];
        // Rotate up by one lane: result lane i takes operand lane i-1.
        OP_ROT:   lane_res = s1_a[((i + LANES - 1) % LANES)*LANE_W +: LANE_W];
        OP_ACCRD: lane_res = acc[i];
        OP_PASS:  lane_res = s1_a[i*LANE_W +: LANE_W];
        default:  lane_res = lane_arith;
      endcase

      res_next[i*LANE_W +: LANE_W] = lane_res;

      // VMAC writes back the (possibly clamped) lane result; VACCRD clears.
      acc_next[i] = (s1_op == OP_MAC) ? lane_arith : '0;
    end
  end

  // The bank changes only as a VMAC/VACCRD moves into stage 2, so an op
  // directly behind it in stage 1 sees the updated value next cycle.
  assign acc_we = adv && s1_valid && ((s1_op == OP_MAC) || (s1_op == OP_ACCRD));

  // -------------------------------------------------------------------------
  // Stage 1 register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      // Stage 1 is free or draining this cycle: take whatever is offered.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= in_op;
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 (output) register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= '0;
      out_zero   <= 1'b1;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_next;
        out_ovf    <= ovf_next;
        out_zero   <= (res_next == '0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Accumulator bank
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
    end else if (acc_we) begin
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= acc_next[i];
      end
    end
  end

endmodule

// File: tb/tb_vector_alu_pipe.sv
// tb_vector_alu_pipe
// Directed bench for vector_alu_pipe at LANES=16, LANE_W=16. Inputs are
// driven 1 time unit after the rising edge; outputs are checked either at
// that point or at the falling edge by the output monitor, which pops
// expected {result, ovf, zero} words from exp_q in acceptance order.
module tb_vector_alu_pipe;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int VW     = LANES * LANE_W;
  localparam int PW     = VW + LANES + 1;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_MAC   = 3'b100;
  localparam logic [2:0] OP_ROT   = 3'b101;
  localparam logic [2:0] OP_ACCRD = 3'b110;
  localparam logic [2:0] OP_PASS  = 3'b111;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [VW-1:0]    in_a;
  logic [VW-1:0]    in_b;
  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    out_result;
  logic [LANES-1:0] out_ovf;
  logic             out_zero;

  always #5 clk = ~clk;

  vector_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [PW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input logic [15:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] pk(input logic [VW-1:0] r, input logic [LANES-1:0] o,
                                       input logic z);
    return {r, o, z};
  endfunction

  // Output monitor: every completed output transfer must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_out: observed=%0h expected=none", out_result);
      end else begin
        check($sformatf("out%0d", n_out), {out_result, out_ovf, out_zero}, exp_q.pop_front());
      end
      n_out++;
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [PW-1:0] exp);
    int  n;
    logic hs;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    n        = 0;
    hs       = 1'b0;
    forever begin
      hs = in_ready;
      tick();
      if (hs) break;
      n++;
      if (n > 50) begin
        n_cmp++;
        n_err++;
        $error("FAIL send_timeout: observed=in_ready_low expected=accept");
        break;
      end
    end
    if (hs) exp_q.push_back(exp);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      tick();
      n++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  logic [VW-1:0] va;
  logic [VW-1:0] vb;
  logic [VW-1:0] vr;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  in_ready,   1);
    check("rst_out_valid", out_valid,  0);
    check("rst_out_result", out_result, 0);
    check("rst_out_ovf",   out_ovf,    0);
    check("rst_out_zero",  out_zero,   1);

    // Latency: VADD 3+4 in every lane
    in_valid = 1'b1;
    in_op    = OP_ADD;
    in_a     = rep(16'h0003);
    in_b     = rep(16'h0004);
    tick();
    exp_q.push_back(pk(rep(16'h0007), '0, 1'b0));
    in_valid = 1'b0;
    check("lat_edge1_valid", out_valid, 0);
    tick();
    check("lat_edge2_valid", out_valid, 1);
    wait_drain("lat");

    // Signed overflow on lane 0 of a VADD
    va = '0; va[15:0] = 16'h7FFF;
    vb = '0; vb[15:0] = 16'h0001;
    vr = '0;
`ifdef VALU_SAT_EN
    vr[15:0] = 16'h7FFF;
`else
    vr[15:0] = 16'h8000;
`endif
    send(OP_ADD, va, vb, pk(vr, 16'h0001, 1'b0));

    // Negative overflow on lane 0 of a VSUB; other lanes 0-1 = -1
    va = '0; va[15:0] = 16'h8000;
    vr = rep(16'hFFFF);
`ifdef VALU_SAT_EN
    vr[15:0] = 16'h8000;
`else
    vr[15:0] = 16'h7FFF;
`endif
    send(OP_SUB, va, rep(16'h0001), pk(vr, 16'h0001, 1'b0));

    // VAND, VMUL (signed), VMUL overflow, VPASS back-to-back
    send(OP_AND, rep(16'hF0F0), rep(16'h0FF0), pk(rep(16'h00F0), '0, 1'b0));
    send(OP_MUL, rep(16'h0003), rep(16'hFFFB), pk(rep(16'hFFF1), '0, 1'b0));
`ifdef VALU_SAT_EN
    send(OP_MUL, rep(16'h0100), rep(16'h0100), pk(rep(16'h7FFF), 16'hFFFF, 1'b0));
`else
    send(OP_MUL, rep(16'h0100), rep(16'h0100), pk(rep(16'h0000), 16'hFFFF, 1'b1));
`endif
    send(OP_PASS, rep(16'h1234), rep(16'h5678), pk(rep(16'h1234), '0, 1'b0));
    wait_drain("ops");

    // MAC chain: 2*3, +4*5, +(-1)*6, then read and read-again
    send(OP_MAC,   rep(16'h0002), rep(16'h0003), pk(rep(16'd6),  '0, 1'b0));
    send(OP_MAC,   rep(16'h0004), rep(16'h0005), pk(rep(16'd26), '0, 1'b0));
    send(OP_MAC,   rep(16'hFFFF), rep(16'h0006), pk(rep(16'd20), '0, 1'b0));
    send(OP_ACCRD, '0, '0,                        pk(rep(16'd20), '0, 1'b0));
    send(OP_ACCRD, '0, '0,                        pk('0,           '0, 1'b1));
    wait_drain("mac");

    // VROT with lane i = i, then VSUB of equal operands
    for (int i = 0; i < LANES; i++) begin
      va[i*LANE_W +: LANE_W] = 16'(i);
      vr[i*LANE_W +: LANE_W] = 16'((i + LANES - 1) % LANES);
    end
    send(OP_ROT, va, rep(16'hDEAD), pk(vr, '0, 1'b0));
    for (int i = 0; i < LANES; i++) va[i*LANE_W +: LANE_W] = 16'($urandom_range(1, 65535));
    send(OP_SUB, va, va, pk('0, '0, 1'b1));
    wait_drain("rot");

    // Stall: out_ready low, in_valid held high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = OP_PASS;
    in_a      = rep(16'h0011);
    in_b      = '0;
    tick();
    exp_q.push_back(pk(rep(16'h0011), '0, 1'b0));
    check("stall_rdy_after1", in_ready, 1);
    in_a = rep(16'h0022);
    tick();
    exp_q.push_back(pk(rep(16'h0022), '0, 1'b0));
    check("stall_rdy_after2", in_ready, 0);
    check("stall_valid", out_valid, 1);
    in_a = rep(16'h0033);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall_hold%0d", k), out_result, rep(16'h0011));
      check($sformatf("stall_rdy%0d", k), in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    exp_q.push_back(pk(rep(16'h0033), '0, 1'b0));
    in_valid = 1'b0;
    send(OP_PASS, rep(16'h0044), '0, pk(rep(16'h0044), '0, 1'b0));
    wait_drain("stall");

    // Reset with two ops in flight and a nonzero accumulator
    send(OP_MAC, rep(16'h0002), rep(16'h0003), pk(rep(16'd6), '0, 1'b0));
    wait_drain("pre_rst");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = OP_ADD;
    in_a      = rep(16'h0001);
    in_b      = rep(16'h0001);
    tick();
    tick();
    in_valid = 1'b0;
    check("rst_inflight_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    exp_q.delete();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    check("rst_mid_ready", in_ready, 1);
    send(OP_ACCRD, '0, '0, pk('0, '0, 1'b1));
    wait_drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
